// File: rtl/cook_timer.sv
// Microwave cook timer: BCD MM:SS keypad entry, prescaled countdown, done flag and strobe.
// Optional feature: define COOK_TIMER_ADD30_EN to add the add30 (+30 s) strobe input.
module cook_timer #(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clearn,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       mag_on,
`ifdef COOK_TIMER_ADD30_EN
    input  logic       add30,
`endif
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done,
    output logic       done_pulse
);

    localparam logic [15:0] LAST_TICK = 16'(TICKS_PER_SEC - 1);

    logic [15:0] presc;
    logic [15:0] presc_next;
    logic        time_nz;
    logic        counting;
    logic        wrap;
    logic        entry;
    logic        do_add;
    logic [3:0]  d_mt, d_mo, d_st, d_so;
    logic [3:0]  a_mt, a_mo, a_st, a_so;
    logic [4:0]  st_sum;
    logic [3:0]  n_mt, n_mo, n_st, n_so;
    logic        dec_zero;
    logic        pulse_next;

`ifdef COOK_TIMER_ADD30_EN
    assign do_add = add30;
`else
    assign do_add = 1'b0;
`endif

    always_comb begin
        time_nz  = |{min_tens, min_ones, sec_tens, sec_ones};
        counting = mag_on && time_nz;
        wrap     = counting && (presc == LAST_TICK);
        entry    = key_valid && !mag_on && (key_digit <= 4'd9);

        // Prescaler keeps its partial second while paused and rests at 0 once at 00:00.
        presc_next = presc;
        if (!time_nz)
            presc_next = '0;
        else if (counting)
            presc_next = wrap ? '0 : presc + 16'd1;

        // One-second BCD decrement; minutes never underflow because time is nonzero on a wrap.
        d_mt = min_tens;
        d_mo = min_ones;
        d_st = sec_tens;
        d_so = sec_ones;
        if (sec_ones != 4'd0) begin
            d_so = sec_ones - 4'd1;
        end else begin
            d_so = 4'd9;
            if (sec_tens != 4'd0) begin
                d_st = sec_tens - 4'd1;
            end else begin
                d_st = 4'd5;
                if (min_ones != 4'd0) begin
                    d_mo = min_ones - 4'd1;
                end else begin
                    d_mo = 4'd9;
                    d_mt = min_tens - 4'd1;
                end
            end
        end
        dec_zero = ({d_mt, d_mo, d_st, d_so} == 16'h0000);

        // +30 s with carry into minutes, saturating at 99:59.
        a_mt   = min_tens;
        a_mo   = min_ones;
        a_so   = sec_ones;
        st_sum = {1'b0, sec_tens} + 5'd3;
        a_st   = st_sum[3:0];
        if (st_sum > 5'd5) begin
            a_st = 4'(st_sum - 5'd6);
            if (min_ones != 4'd9) begin
                a_mo = min_ones + 4'd1;
            end else if (min_tens != 4'd9) begin
                a_mo = 4'd0;
                a_mt = min_tens + 4'd1;
            end else begin
                a_mt = 4'd9;
                a_mo = 4'd9;
                a_st = 4'd5;
                a_so = 4'd9;
            end
        end

        n_mt = min_tens;
        n_mo = min_ones;
        n_st = sec_tens;
        n_so = sec_ones;
        pulse_next = 1'b0;
        if (do_add) begin
            n_mt = a_mt;
            n_mo = a_mo;
            n_st = a_st;
            n_so = a_so;
        end else if (wrap) begin
            n_mt = d_mt;
            n_mo = d_mo;
            n_st = d_st;
            n_so = d_so;
            pulse_next = dec_zero;
        end else if (entry) begin
            n_mt = min_ones;
            n_mo = sec_tens;
            n_st = sec_ones;
            n_so = key_digit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !clearn) begin
            min_tens   <= '0;
            min_ones   <= '0;
            sec_tens   <= '0;
            sec_ones   <= '0;
            presc      <= '0;
            timer_done <= 1'b1;
            done_pulse <= 1'b0;
        end else begin
            min_tens   <= n_mt;
            min_ones   <= n_mo;
            sec_tens   <= n_st;
            sec_ones   <= n_so;
            presc      <= presc_next;
            timer_done <= ({n_mt, n_mo, n_st, n_so} == 16'h0000);
            done_pulse <= pulse_next;
        end
    end

endmodule

// File: tb/tb_cook_timer.sv
// Directed bench for cook_timer at TICKS_PER_SEC=4; add30 scenarios compile in with COOK_TIMER_ADD30_EN.
module tb_cook_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       clearn;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       mag_on;
    logic       add30;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       timer_done, done_pulse;
    logic [15:0] disp;

    int n_checks = 0;
    int n_pass   = 0;

    assign disp = {min_tens, min_ones, sec_tens, sec_ones};

    always #5 clk = ~clk;

    cook_timer #(.TICKS_PER_SEC(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .clearn    (clearn),
        .key_valid (key_valid),
        .key_digit (key_digit),
        .mag_on    (mag_on),
`ifdef COOK_TIMER_ADD30_EN
        .add30     (add30),
`endif
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .timer_done(timer_done),
        .done_pulse(done_pulse)
    );

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_time();
        clearn = 1'b0;
        tick();
        clearn = 1'b1;
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic load(input logic [15:0] t);
        clear_time();
        mag_on = 1'b0;
        press(t[15:12]);
        press(t[11:8]);
        press(t[7:4]);
        press(t[3:0]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (disp !== 16'h0000) $display("FAIL reset_digits got %h want 0000", disp);
        else n_pass++;
        n_checks++;
        if (timer_done !== 1'b1) $display("FAIL reset_done got %b want 1", timer_done);
        else n_pass++;
        n_checks++;
        if (done_pulse !== 1'b0) $display("FAIL reset_pulse got %b want 0", done_pulse);
        else n_pass++;
    endtask

    task automatic test_entry();
        clear_time();
        press(4'd1);
        press(4'd3);
        press(4'd0);
        n_checks++;
        if (disp !== 16'h0130) $display("FAIL entry_130 got %h want 0130", disp);
        else n_pass++;
        n_checks++;
        if (timer_done !== 1'b0) $display("FAIL entry_done got %b want 0", timer_done);
        else n_pass++;
        press(4'd12);
        n_checks++;
        if (disp !== 16'h0130) $display("FAIL entry_bad_digit got %h want 0130", disp);
        else n_pass++;
        mag_on = 1'b1;
        press(4'd7);
        mag_on = 1'b0;
        n_checks++;
        if (disp !== 16'h0130) $display("FAIL entry_while_on got %h want 0130", disp);
        else n_pass++;
        clearn = 1'b0;
        press(4'd5);
        clearn = 1'b1;
        n_checks++;
        if (disp !== 16'h0000) $display("FAIL clear_over_entry got %h want 0000", disp);
        else n_pass++;
    endtask

    task automatic test_count();
        int pulses;
        load(16'h0002);
        mag_on = 1'b1;
        tick(3);
        n_checks++;
        if (disp !== 16'h0002) $display("FAIL count_3cyc got %h want 0002", disp);
        else n_pass++;
        tick();
        n_checks++;
        if (disp !== 16'h0001) $display("FAIL count_4cyc got %h want 0001", disp);
        else n_pass++;
        tick(3);
        n_checks++;
        if (done_pulse !== 1'b0 || disp !== 16'h0001)
            $display("FAIL count_7cyc got %h/%b want 0001/0", disp, done_pulse);
        else n_pass++;
        tick();
        n_checks++;
        if (disp !== 16'h0000 || timer_done !== 1'b1 || done_pulse !== 1'b1)
            $display("FAIL count_8cyc got %h/%b/%b want 0000/1/1", disp, timer_done, done_pulse);
        else n_pass++;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done_pulse !== 1'b0 || disp !== 16'h0000) pulses++;
        end
        n_checks++;
        if (pulses !== 0) $display("FAIL count_hold_zero got %0d bad cycles want 0", pulses);
        else n_pass++;
        mag_on = 1'b0;
    endtask

    task automatic test_borrow();
        logic [15:0] exp;
        int bad;
        int pulses;
        load(16'h0100);
        mag_on = 1'b1;
        tick(4);
        mag_on = 1'b0;
        n_checks++;
        if (disp !== 16'h0059) $display("FAIL borrow_0100 got %h want 0059", disp);
        else n_pass++;
        load(16'h0090);
        mag_on = 1'b1;
        bad = 0;
        pulses = 0;
        for (int n = 89; n >= 0; n--) begin
            tick(4);
            exp = {8'h00, 4'(n / 10), 4'(n % 10)};
            if (disp !== exp) begin
                if (bad == 0) $display("FAIL borrow_0090 got %h want %h", disp, exp);
                bad++;
            end
            if (done_pulse === 1'b1) pulses++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL borrow_0090_seq got %0d bad seconds want 0", bad);
        else n_pass++;
        n_checks++;
        if (pulses !== 1) $display("FAIL borrow_0090_pulse got %0d pulses want 1", pulses);
        else n_pass++;
        mag_on = 1'b0;
    endtask

    task automatic test_pause();
        load(16'h0005);
        mag_on = 1'b1;
        tick(2);
        mag_on = 1'b0;
        tick(10);
        n_checks++;
        if (disp !== 16'h0005) $display("FAIL pause_hold got %h want 0005", disp);
        else n_pass++;
        mag_on = 1'b1;
        tick();
        n_checks++;
        if (disp !== 16'h0005) $display("FAIL pause_resume3 got %h want 0005", disp);
        else n_pass++;
        tick();
        n_checks++;
        if (disp !== 16'h0004) $display("FAIL pause_resume4 got %h want 0004", disp);
        else n_pass++;
        tick(2);
        clearn = 1'b0;
        tick();
        clearn = 1'b1;
        n_checks++;
        if (disp !== 16'h0000 || done_pulse !== 1'b0 || timer_done !== 1'b1)
            $display("FAIL clear_mid_count got %h/%b/%b want 0000/0/1", disp, done_pulse, timer_done);
        else n_pass++;
        mag_on = 1'b0;
    endtask

    task automatic test_reset_mid();
        int pulses;
        load(16'h0001);
        mag_on = 1'b1;
        tick(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pulses = (done_pulse === 1'b1) ? 1 : 0;
        n_checks++;
        if (disp !== 16'h0000) $display("FAIL reset_mid_digits got %h want 0000", disp);
        else n_pass++;
        tick(5);
        if (done_pulse === 1'b1) pulses++;
        n_checks++;
        if (pulses !== 0) $display("FAIL reset_mid_pulse got %0d want 0", pulses);
        else n_pass++;
        mag_on = 1'b0;
    endtask

`ifdef COOK_TIMER_ADD30_EN
    task automatic test_add30();
        load(16'h0045);
        add30 = 1'b1;
        tick();
        add30 = 1'b0;
        n_checks++;
        if (disp !== 16'h0115) $display("FAIL add30_0045 got %h want 0115", disp);
        else n_pass++;
        load(16'h9950);
        add30 = 1'b1;
        tick();
        add30 = 1'b0;
        n_checks++;
        if (disp !== 16'h9959) $display("FAIL add30_clamp got %h want 9959", disp);
        else n_pass++;
        load(16'h0010);
        mag_on = 1'b1;
        tick(3);
        add30 = 1'b1;
        tick();
        add30 = 1'b0;
        n_checks++;
        if (disp !== 16'h0040) $display("FAIL add30_on_wrap got %h want 0040", disp);
        else n_pass++;
        tick(4);
        n_checks++;
        if (disp !== 16'h0039) $display("FAIL add30_after_wrap got %h want 0039", disp);
        else n_pass++;
        mag_on = 1'b0;
        add30  = 1'b1;
        clearn = 1'b0;
        tick();
        add30  = 1'b0;
        clearn = 1'b1;
        n_checks++;
        if (disp !== 16'h0000) $display("FAIL add30_with_clear got %h want 0000", disp);
        else n_pass++;
    endtask
`endif

    initial begin
        rst       = 1'b1;
        clearn    = 1'b1;
        key_valid = 1'b0;
        key_digit = 4'd0;
        mag_on    = 1'b0;
        add30     = 1'b0;
        tick(2);
        test_reset();
        test_entry();
        test_count();
        test_borrow();
        test_pause();
        test_reset_mid();
`ifdef COOK_TIMER_ADD30_EN
        test_add30();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
